// File: rtl/div32_seq.sv
// Sequential radix-2 non-restoring divider. Produces {remainder, quotient} in the
// HI/LO layout, one quotient bit per clock, with start/busy/done handshaking.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 dbz,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     div_q;
    logic                 neg_q_q;
    logic                 neg_r_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;
    logic [2*WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]     dvd_mag_d;
    logic [WIDTH-1:0]     dvs_mag_d;
    logic [WIDTH:0]       d_ext_d;
    logic [WIDTH:0]       rem_shift_d;
    logic [WIDTH:0]       rem_step_d;
    logic [WIDTH-1:0]     rem_fix_d;
    logic [WIDTH-1:0]     quo_out_d;
    logic [WIDTH-1:0]     rem_out_d;

    // The most-negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
    always_comb begin
        dvd_mag_d = dividend;
        dvs_mag_d = divisor;
        if (signed_op && dividend[WIDTH-1]) begin
            dvd_mag_d = -dividend;
        end
        if (signed_op && divisor[WIDTH-1]) begin
            dvs_mag_d = -divisor;
        end
    end

    // Remainder arithmetic wraps at WIDTH+1 bits; the retained value always lies in [-D, D).
    always_comb begin
        d_ext_d     = {1'b0, div_q};
        rem_shift_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_step_d  = rem_q[WIDTH] ? (rem_shift_d + d_ext_d) : (rem_shift_d - d_ext_d);
        rem_fix_d   = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + div_q) : rem_q[WIDTH-1:0];
        quo_out_d   = neg_q_q ? -quo_q : quo_q;
        rem_out_d   = neg_r_q ? -rem_fix_d : rem_fix_d;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        neg_q_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_q <= signed_op & dividend[WIDTH-1];
                        rem_q   <= '0;
                        div_q   <= dvs_mag_d;
                        cnt_q   <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        if (divisor == '0) begin
                            // Raw dividend is parked in the quotient register for the HI word.
                            quo_q   <= dividend;
                            state_q <= S_DONE;
                        end else begin
                            quo_q   <= dvd_mag_d;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_step_d;
                    quo_q <= {quo_q[WIDTH-2:0], ~rem_step_d[WIDTH]};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= {rem_out_d, quo_out_d};
                    dbz_q    <= 1'b0;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        // Reached straight from IDLE on a zero divisor: report it now.
                        result_q <= {quo_q, {WIDTH{1'b1}}};
                        dbz_q    <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign dbz    = dbz_q;
    assign result = result_q;

endmodule

// File: tb/tb_div32_seq.sv
// Randomised scoreboard bench for div32_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div32_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [63:0] result;

    div32_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          cyc;
        int          bcy;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          busy_run = 0;
    int          done_count = 0;
    logic [63:0] hold_res = '0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint      qq;
        longint      rr;
        logic [63:0] qv;
        logic [63:0] rv;
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end
        if (s) begin
            qq = longint'($signed(a)) / longint'($signed(b));
            rr = longint'($signed(a)) % longint'($signed(b));
        end else begin
            qq = longint'({32'd0, a}) / longint'({32'd0, b});
            rr = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        qv = qq;
        rv = rr;
        return {rv[31:0], qv[31:0]};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                busy_run++;
                if (!done) check("hold_while_busy", result, hold_res);
            end
            if (done) begin
                done_count++;
                if (sb_q.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("op %h / %h signed=%0d -> result=%h dbz=%0d (exp %h dbz=%0d) at cycle %0d",
                             e.a, e.b, e.s, result, dbz, e.res, e.dbz, cyc);
                    check("result", result, e.res);
                    check("dbz", 64'(dbz), 64'(e.dbz));
                    check("latency", 64'(cyc), 64'(e.cyc));
                    check("busy_cycles", 64'(busy_run), 64'(e.bcy));
                    check("busy_low_at_done", 64'(busy), 64'd0);
                end
                hold_res = result;
                busy_run = 0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        wait_idle();
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        signed_op = s;
        e.res = ref_div(a, b, s);
        e.dbz = (b == 32'd0);
        e.cyc = cyc + ((b == 32'd0) ? 2 : 34);
        e.bcy = (b == 32'd0) ? 1 : 33;
        e.a   = a;
        e.b   = b;
        e.s   = s;
        sb_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) begin
            check("done_timeout", 64'd1, 64'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          dc;
        int          n;

        clr       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dbz", 64'(dbz), 64'd0);
        check("reset_result", result, 64'd0);
        clr    = 1'b0;
        mon_en = 1'b1;

        // Directed cases
        issue(32'd100, 32'd7, 1'b0);               wait_done();
        check("u100_7_literal", hold_res, {32'h2, 32'hE});
        issue(-32'sd100, 32'd7, 1'b1);             wait_done();
        check("sm100_7_literal", hold_res, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        issue(32'd100, -32'sd7, 1'b1);             wait_done();
        issue(32'h1234_5678, 32'd0, 1'b0);         wait_done();
        issue(32'd55, 32'd5, 1'b1);                wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done();
        check("overflow_literal", hold_res, {32'h0, 32'h8000_0000});
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);         wait_done();
        issue(32'd5, 32'd9, 1'b0);                 wait_done();
        issue(32'h8000_0000, 32'd3, 1'b1);         wait_done();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done();

        // Restart attempts mid-operation and during the done cycle are ignored
        issue(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd7; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1; dividend = 32'd9; divisor = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("start_during_done_ignored", 64'(busy), 64'd0);
        dc = done_count;
        repeat (40) @(negedge clk);
        check("single_done", 64'(done_count), 64'(dc));

        // Abort mid-CALC via clr
        issue(32'd50000, 32'd13, 1'b1);
        repeat (13) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", result, 64'd0);
        sb_q.delete();
        hold_res = '0;
        busy_run = 0;
        dc = done_count;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 64'(done_count), 64'(dc));
        issue(32'd81, 32'd9, 1'b0);                wait_done();
        check("after_abort_literal", hold_res, {32'h0, 32'h9});

        // Randomised operations
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            issue(a, b, s);
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
